// File: rtl/pe_rank_uv_controller_pkg.sv
// rtl/pe_rank_uv_controller_pkg.sv - shared widths, packet fields and FSM states for the PE UV rank controller
package pe_rank_uv_controller_pkg;

    localparam int RANK_WIDTH        = 6;
    localparam int ROUTER_WIDTH      = 36;
    localparam int DATA_WIDTH        = 16;
    localparam int ROUTER_ADDR_WIDTH = 16;
    localparam int ROUTER_INFO_WIDTH = 4;

    // Packet layout: [35:32] info, [31:16] addr, [15:0] data
    localparam int PKT_DATA_LSB = 0;
    localparam int PKT_ADDR_LSB = DATA_WIDTH;
    localparam int PKT_INFO_LSB = DATA_WIDTH + ROUTER_ADDR_WIDTH;

    localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_UV = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2
    } uv_state_t;

    // Builds a UV packet carrying one rank entry; the rank index is zero-extended into the addr field
    function automatic logic [ROUTER_WIDTH-1:0] pack_uv(
        input logic [RANK_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0] data
    );
        return {ROUTER_INFO_UV, {(ROUTER_ADDR_WIDTH-RANK_WIDTH){1'b0}}, idx, data};
    endfunction

endpackage

// File: rtl/pe_rank_uv_controller_if.sv
// rtl/pe_rank_uv_controller_if.sv - PV buffer, V buffer, router and control signals of the UV rank controller
interface pe_rank_uv_controller_if;
    import pe_rank_uv_controller_pkg::*;

    logic                    start;
    logic                    uv_en;
    logic [RANK_WIDTH-1:0]   rank_no;
    logic                    pv_re;
    logic [RANK_WIDTH-1:0]   pv_raddr;
    logic [DATA_WIDTH-1:0]   pv_rdata;
    logic                    router_rdy;
    logic                    out_data_valid;
    logic [ROUTER_WIDTH-1:0] out_data;
    logic                    in_data_valid;
    logic [ROUTER_WIDTH-1:0] in_data;
    logic                    v_we;
    logic [RANK_WIDTH-1:0]   v_waddr;
    logic [DATA_WIDTH-1:0]   v_wdata;
    logic                    busy;
    logic                    done;

    // Controller side
    modport master (
        input  start, uv_en, rank_no, pv_rdata, router_rdy, in_data_valid, in_data,
        output pv_re, pv_raddr, out_data_valid, out_data, v_we, v_waddr, v_wdata, busy, done
    );

    // PE datapath / buffers / router side
    modport slave (
        output start, uv_en, rank_no, pv_rdata, router_rdy, in_data_valid, in_data,
        input  pv_re, pv_raddr, out_data_valid, out_data, v_we, v_waddr, v_wdata, busy, done
    );

endinterface

// File: rtl/pe_rank_uv_controller.sv
// rtl/pe_rank_uv_controller.sv - sends partial-V rank entries to the root and collects the UV broadcast back
module pe_rank_uv_controller
    import pe_rank_uv_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    pe_rank_uv_controller_if.master bus
);

    uv_state_t             state;
    logic [RANK_WIDTH-1:0] tx_idx;
    logic [RANK_WIDTH-1:0] rx_cnt;
    logic [RANK_WIDTH-1:0] rank_lat;
    logic                  done_q;

    logic [ROUTER_INFO_WIDTH-1:0] in_info;
    logic [RANK_WIDTH-1:0]        in_addr;
    logic [DATA_WIDTH-1:0]        in_word;

    logic                  tx_fire;
    logic                  rx_fire;
    logic [RANK_WIDTH-1:0] tx_idx_next;
    logic [RANK_WIDTH-1:0] rx_cnt_next;

    assign in_info = bus.in_data[PKT_INFO_LSB +: ROUTER_INFO_WIDTH];
    assign in_addr = bus.in_data[PKT_ADDR_LSB +: RANK_WIDTH];
    assign in_word = bus.in_data[PKT_DATA_LSB +: DATA_WIDTH];

    // Transfer decisions and counter increments; tx and rx are independent and may fire together
    always_comb begin
        tx_fire     = (state == ST_SEND) && (tx_idx < rank_lat) && bus.router_rdy;
        rx_fire     = (state != ST_IDLE) && bus.in_data_valid && (in_info == ROUTER_INFO_UV);
        tx_idx_next = tx_idx + {{(RANK_WIDTH-1){1'b0}}, tx_fire};
        rx_cnt_next = rx_cnt + {{(RANK_WIDTH-1){1'b0}}, rx_fire};
    end

    // Outputs are forced to zero whenever their strobe is low so idle buses stay quiet
    assign bus.pv_re          = tx_fire;
    assign bus.pv_raddr       = tx_fire ? tx_idx : '0;
    assign bus.out_data_valid = tx_fire;
    assign bus.out_data       = tx_fire ? pack_uv(tx_idx, bus.pv_rdata) : '0;
    assign bus.v_we           = rx_fire;
    assign bus.v_waddr        = rx_fire ? in_addr : '0;
    assign bus.v_wdata        = rx_fire ? in_word : '0;
    assign bus.busy           = (state != ST_IDLE);
    assign bus.done           = done_q;

    // Layer FSM: latch rank count on start, stream tx, count rx, pulse done once both sides complete
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_idx   <= '0;
            rx_cnt   <= '0;
            rank_lat <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && bus.uv_en) begin
                        rank_lat <= bus.rank_no;
                        tx_idx   <= '0;
                        rx_cnt   <= '0;
                        if (bus.rank_no != '0) begin
                            state <= ST_SEND;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    tx_idx <= tx_idx_next;
                    rx_cnt <= rx_cnt_next;
                    if (tx_idx_next == rank_lat) begin
                        if (rx_cnt_next == rank_lat) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    rx_cnt <= rx_cnt_next;
                    if (rx_cnt_next == rank_lat) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_rank_uv_controller.sv
// tb/tb_pe_rank_uv_controller.sv - randomized scoreboard bench for the PE UV rank controller
module tb_pe_rank_uv_controller;
    import pe_rank_uv_controller_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_rank_uv_controller_if bus();

    pe_rank_uv_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] pv_mem [0:63];
    assign bus.pv_rdata = pv_mem[bus.pv_raddr];

    // Reference model: a layer is a count of entries to send and to receive
    bit m_active;
    bit m_pend;
    int m_n;
    int m_tx;
    int m_rx;
    bit chk_en;
    bit exp_busy;
    bit exp_done;

    logic [35:0] tx_q [$];
    logic [21:0] rx_q [$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fill_pv();
        for (int i = 0; i < 64; i++) pv_mem[i] = 16'($urandom);
    endtask

    // One clock of stimulus; the model predicts what the controller must do this cycle
    task automatic step(input bit st, input bit en, input int rn, input bit rdy,
                        input bit iv, input logic [35:0] id, input bit r);
        @(posedge clk);
        #1;
        rst               = r;
        bus.start         = st;
        bus.uv_en         = en;
        bus.rank_no       = 6'(rn);
        bus.router_rdy    = rdy;
        bus.in_data_valid = iv;
        bus.in_data       = iv ? id : 36'h0;
        if (r) begin
            chk_en   = 1'b0;
            m_active = 1'b0;
            m_pend   = 1'b0;
            tx_q.delete();
            rx_q.delete();
        end else begin
            chk_en   = 1'b1;
            exp_busy = m_active;
            exp_done = m_pend;
            m_pend   = 1'b0;
            if (m_active) begin
                if (m_tx < m_n && rdy) begin
                    tx_q.push_back({ROUTER_INFO_UV, 10'h0, 6'(m_tx), pv_mem[m_tx]});
                    m_tx++;
                end
                if (iv && id[35:32] == ROUTER_INFO_UV) begin
                    rx_q.push_back({id[21:16], id[15:0]});
                    m_rx++;
                end
                if (m_tx == m_n && m_rx == m_n) begin
                    m_active = 1'b0;
                    m_pend   = 1'b1;
                end
            end else if (st && en) begin
                m_n  = rn;
                m_tx = 0;
                m_rx = 0;
                if (rn == 0) m_pend = 1'b1;
                else m_active = 1'b1;
            end
        end
    endtask

    function automatic logic [35:0] uv_pkt();
        return {ROUTER_INFO_UV, 16'($urandom), 16'($urandom)};
    endfunction

    function automatic logic [35:0] other_pkt();
        logic [3:0] info;
        info = 4'($urandom);
        if (info == ROUTER_INFO_UV) info = info + 4'd1;
        return {info, 16'($urandom), 16'($urandom)};
    endfunction

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) step(0, 1, 0, rdy, 0, 36'h0, 0);
    endtask

    // Full layer with random ready/receive traffic; rdy_mode 0 always, 1 pattern 1,0,0, 2 random
    task automatic run_layer(input int n, input int rdy_mode, input bit overlap);
        int cyc;
        bit rdy;
        bit iv;
        bit st;
        logic [35:0] id;
        fill_pv();
        step(1, 1, n, 1, 0, 36'h0, 0);
        cyc = 0;
        while ((m_active || m_pend) && cyc < 400) begin
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            iv = 1'b0;
            id = 36'h0;
            if ($urandom_range(0, 3) == 0) begin
                iv = 1'b1;
                id = other_pkt();
            end else if ((overlap || m_tx == m_n) && m_active && m_rx < m_n && $urandom_range(0, 1) == 1) begin
                iv = 1'b1;
                id = uv_pkt();
            end
            st = m_active && ($urandom_range(0, 7) == 0);
            step(st, 1, int'($urandom_range(0, 63)), rdy, iv, id, 0);
            cyc++;
        end
        if (cyc >= 400) begin
            checks++;
            $display("FAIL layer_timeout: layer of %0d entries not finished within 400 cycles", n);
        end
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard queues and model flags
    always @(negedge clk) begin
        logic [35:0] e;
        logic [21:0] w;
        if (chk_en) begin
            check("busy", 64'(bus.busy), 64'(exp_busy));
            check("done", 64'(bus.done), 64'(exp_done));
            if (bus.out_data_valid) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    $display("FAIL tx_unexpected: got packet %0h expected none", bus.out_data);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_packet", 64'(bus.out_data), 64'(e));
                    check("pv_read", 64'({bus.pv_re, bus.pv_raddr}), 64'({1'b1, e[21:16]}));
                end
            end else begin
                check("tx_quiet", 64'({bus.pv_re, bus.pv_raddr, bus.out_data}), 64'(0));
            end
            if (bus.v_we) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    $display("FAIL rx_unexpected: got write %0h/%0h expected none", bus.v_waddr, bus.v_wdata);
                end else begin
                    w = rx_q.pop_front();
                    check("v_write", 64'({bus.v_waddr, bus.v_wdata}), 64'(w));
                end
            end else begin
                check("rx_quiet", 64'({bus.v_waddr, bus.v_wdata}), 64'(0));
            end
        end
    end

    initial begin
        chk_en            = 1'b0;
        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.uv_en         = 1'b0;
        bus.rank_no       = '0;
        bus.router_rdy    = 1'b0;
        bus.in_data_valid = 1'b0;
        bus.in_data       = '0;
        fill_pv();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 36'h0, 1);
        idle(2, 1);

        // Four entries back to back, then four UV inputs
        step(1, 1, 4, 1, 0, 36'h0, 0);
        idle(4, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 1, uv_pkt(), 0);
        idle(2, 1);

        // Stalled router
        run_layer(3, 1, 0);
        idle(1, 0);

        // Root echoes during SEND; second UV lands on the last tx cycle
        fill_pv();
        step(1, 1, 2, 1, 0, 36'h0, 0);
        step(0, 1, 0, 1, 1, uv_pkt(), 0);
        step(0, 1, 0, 1, 1, uv_pkt(), 0);
        idle(2, 1);

        // Zero-rank layer and start with UV disabled
        step(1, 1, 0, 1, 0, 36'h0, 0);
        idle(2, 1);
        step(1, 0, 5, 1, 0, 36'h0, 0);
        idle(3, 1);

        // Traffic while idle must not write V
        step(0, 1, 0, 1, 1, uv_pkt(), 0);
        step(0, 1, 0, 1, 1, other_pkt(), 0);
        step(0, 1, 0, 1, 1, uv_pkt(), 0);
        run_layer(4, 0, 1);

        // Reset after two of five packets, then a fresh layer from index 0
        fill_pv();
        step(1, 1, 5, 1, 0, 36'h0, 0);
        idle(2, 1);
        step(0, 1, 0, 0, 0, 36'h0, 1);
        idle(2, 1);
        run_layer(5, 0, 0);

        // Largest layer plus random layers
        run_layer(63, 0, 1);
        for (int i = 0; i < 20; i++)
            run_layer(int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        idle(3, 1);

        check("tx_q_drained", 64'(tx_q.size()), 64'(0));
        check("rx_q_drained", 64'(rx_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
